// File: rtl/ram_lsu.sv
// ram_lsu: byte-addressable little-endian data RAM behind a valid/ready load/store port.
// Handles byte/half/word (and dword when W=64) accesses. Loads are sign- or zero-extended.
// Each request is range checked, and read data comes out of a register.
// Build option: define RAM_MISALIGN_EN to split word-crossing accesses into two beats.
// Without it, every misaligned access is rejected and req_ready is tied high.
module ram_lsu #(
  parameter int W = 32,
  parameter int L = 64,
  localparam int AW = $clog2(L*W/8)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [AW-1:0] req_addr,
  input  logic [W-1:0]  req_wdata,
  output logic          rsp_valid,
  output logic [W-1:0]  rsp_rdata,
  output logic          rsp_err
);

  localparam int NB = L*W/8;
  localparam int WB = W/8;
  localparam int OB = $clog2(WB);
  localparam logic [4:0]    WB5    = 5'(WB);
  localparam logic [AW+4:0] LAST_A = (AW+5)'(NB-1);

  typedef enum logic {IDLE = 1'b0, BEAT2 = 1'b1} state_t;

  logic [7:0] mem [NB];

  state_t         state_q, state_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic           rsp_err_q, rsp_err_d;

  // request captured at accept, replayed for the second beat
  logic [AW-1:0]  sav_addr_q, sav_addr_d;
  logic [W-1:0]   sav_wdata_q, sav_wdata_d;
  logic [1:0]     sav_size_q, sav_size_d;
  logic           sav_uns_q, sav_uns_d;
  logic           sav_we_q, sav_we_d;
  logic [4:0]     sav_lo_q, sav_lo_d;
  logic [W-1:0]   part_q, part_d;
  logic [4:0]     sav_nb;

  logic           acc, err, split;
  logic [4:0]     nb, off, cnt1;
  logic [AW+4:0]  last;

  // beat view: data byte j lives at beat_base + j; lanes [beat_lo, beat_hi) are active
  logic [AW-1:0]  beat_base;
  logic [4:0]     beat_lo, beat_hi;
  logic [W-1:0]   beat_wdata;
  logic           beat_we, beat_act, wr_en;
  logic [W-1:0]   merged;

  // Sign/zero-extend the low 2**sz bytes of d to the full width.
  function automatic logic [W-1:0] extend(input logic [W-1:0] d, input logic [1:0] sz,
                                          input logic uns);
    int   nbits;
    logic s;
    nbits  = 8 << sz;
    extend = d;
    if (nbits < W) begin
      s = uns ? 1'b0 : d[nbits-1];
      for (int b = 0; b < W; b++) begin
        if (b >= nbits) extend[b] = s;
      end
    end
  endfunction

  assign nb     = 5'd1 << req_size;
  assign off    = 5'(req_addr[OB-1:0]);
  assign last   = {5'd0, req_addr} + {{AW{1'b0}}, nb} - {{(AW+4){1'b0}}, 1'b1};
  assign sav_nb = 5'd1 << sav_size_q;

`ifdef RAM_MISALIGN_EN
  logic cross;
  assign cross     = (off + nb) > WB5;
  assign err       = (nb > WB5) | (last > LAST_A);
  assign split     = cross & ~err;
  assign req_ready = (state_q == IDLE);
`else
  logic mis;
  assign mis       = (off & (nb - 5'd1)) != 5'd0;
  assign err       = (nb > WB5) | (last > LAST_A) | mis;
  assign split     = 1'b0;
  assign req_ready = 1'b1;
`endif

  assign cnt1 = split ? (WB5 - off) : nb;
  assign acc  = req_valid & req_ready;

  // select which request (live or saved) drives the current memory beat
  always_comb begin
    beat_base  = req_addr;
    beat_lo    = 5'd0;
    beat_hi    = cnt1;
    beat_wdata = req_wdata;
    beat_we    = req_we;
    beat_act   = acc & ~err;
    if (state_q == BEAT2) begin
      beat_base  = sav_addr_q;
      beat_lo    = sav_lo_q;
      beat_hi    = sav_nb;
      beat_wdata = sav_wdata_q;
      beat_we    = sav_we_q;
      beat_act   = 1'b1;
    end
    wr_en = beat_act & beat_we & rst_n;
  end

  // read active lanes and merge with the lower-word bytes held from beat 1
  always_comb begin
    merged = '0;
    for (int j = 0; j < WB; j++) begin
      if ((5'(j) >= beat_lo) && (5'(j) < beat_hi))
        merged[8*j +: 8] = mem[beat_base + AW'(j)];
      else if (state_q == BEAT2)
        merged[8*j +: 8] = part_q[8*j +: 8];
    end
  end

  // byte-lane store into the array; the array itself is never reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int j = 0; j < WB; j++) begin
        if ((5'(j) >= beat_lo) && (5'(j) < beat_hi))
          mem[beat_base + AW'(j)] <= beat_wdata[8*j +: 8];
      end
    end
  end

  // next-state and response generation
  always_comb begin
    state_d     = state_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    sav_addr_d  = sav_addr_q;
    sav_wdata_d = sav_wdata_q;
    sav_size_d  = sav_size_q;
    sav_uns_d   = sav_uns_q;
    sav_we_d    = sav_we_q;
    sav_lo_d    = sav_lo_q;
    part_d      = part_q;
    case (state_q)
      IDLE: begin
        if (acc) begin
          sav_addr_d  = req_addr;
          sav_wdata_d = req_wdata;
          sav_size_d  = req_size;
          sav_uns_d   = req_unsigned;
          sav_we_d    = req_we;
          sav_lo_d    = cnt1;
          part_d      = merged;
          if (err) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else if (split) begin
            state_d = BEAT2;
          end else begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = req_we ? '0 : extend(merged, req_size, req_unsigned);
          end
        end
      end
      BEAT2: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = sav_we_q ? '0 : extend(merged, sav_size_q, sav_uns_q);
      end
      default: state_d = IDLE;
    endcase
  end

  // control and response registers, asynchronously reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // saved-request datapath registers, no reset needed
  always_ff @(posedge clk) begin
    sav_addr_q  <= sav_addr_d;
    sav_wdata_q <= sav_wdata_d;
    sav_size_q  <= sav_size_d;
    sav_uns_q   <= sav_uns_d;
    sav_we_q    <= sav_we_d;
    sav_lo_q    <= sav_lo_d;
    part_q      <= part_d;
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_ram_lsu.sv
// tb_ram_lsu: directed bench for ram_lsu (W=32, L=64) with hand-computed expectations.
// Crossing-access scenarios are compiled in when RAM_MISALIGN_EN is defined.
module tb_ram_lsu;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int errors = 0;
  int checks = 0;

  ram_lsu #(.W(32), .L(64)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [7:0] addr, input logic [31:0] wd);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
  endtask

  // single-beat transaction: response expected one edge after accept
  task automatic txn(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                     input logic [7:0] addr, input logic [31:0] wd,
                     input logic [31:0] exp_d, input logic exp_e);
    @(negedge clk);
    drive(we, sz, uns, addr, wd);
    @(negedge clk);
    req_valid = 1'b0;
    check({tag, " vld"}, 32'(rsp_valid), 32'd1);
    check({tag, " err"}, 32'(rsp_err), 32'(exp_e));
    check({tag, " data"}, rsp_rdata, exp_d);
  endtask

`ifdef RAM_MISALIGN_EN
  // word-crossing transaction: ready drops for one cycle, response two edges after accept
  task automatic txn2(input string tag, input logic we, input logic [1:0] sz, input logic uns,
                      input logic [7:0] addr, input logic [31:0] wd, input logic [31:0] exp_d);
    @(negedge clk);
    drive(we, sz, uns, addr, wd);
    @(negedge clk);
    req_valid = 1'b0;
    check({tag, " busy rdy"}, 32'(req_ready), 32'd0);
    check({tag, " busy vld"}, 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check({tag, " vld"}, 32'(rsp_valid), 32'd1);
    check({tag, " err"}, 32'(rsp_err), 32'd0);
    check({tag, " data"}, rsp_rdata, exp_d);
    check({tag, " rdy"}, 32'(req_ready), 32'd1);
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 8'h00; req_wdata = 32'h0;
    #12;
    check("rst ready", 32'(req_ready), 32'd1);
    check("rst valid", 32'(rsp_valid), 32'd0);
    check("rst rdata", rsp_rdata, 32'h0);
    check("rst err",   32'(rsp_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // back-to-back: store word, then signed byte and unsigned half loads
    @(negedge clk);
    drive(1'b1, 2'd2, 1'b0, 8'h10, 32'h8899AABB);
    @(negedge clk);
    check("b2b st vld", 32'(rsp_valid), 32'd1);
    check("b2b st data", rsp_rdata, 32'h0);
    drive(1'b0, 2'd0, 1'b0, 8'h11, 32'h0);
    @(negedge clk);
    check("b2b ldb vld", 32'(rsp_valid), 32'd1);
    check("b2b ldb data", rsp_rdata, 32'hFFFFFFAA);
    drive(1'b0, 2'd1, 1'b1, 8'h12, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    check("b2b ldh vld", 32'(rsp_valid), 32'd1);
    check("b2b ldh data", rsp_rdata, 32'h00008899);
    @(negedge clk);
    check("b2b idle vld", 32'(rsp_valid), 32'd0);
    check("b2b hold data", rsp_rdata, 32'h00008899);

    // asynchronous reset in the middle of a response
    @(negedge clk);
    drive(1'b0, 2'd2, 1'b0, 8'h10, 32'h0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("pre-rst vld", 32'(rsp_valid), 32'd1);
    check("pre-rst data", rsp_rdata, 32'h8899AABB);
    #1 rst_n = 1'b0;
    #1;
    check("arst ready", 32'(req_ready), 32'd1);
    check("arst valid", 32'(rsp_valid), 32'd0);
    check("arst rdata", rsp_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // more sizes and extensions
    txn("ldb u",  1'b0, 2'd0, 1'b1, 8'h10, 32'h0, 32'h000000BB, 1'b0);
    txn("ldh s",  1'b0, 2'd1, 1'b0, 8'h12, 32'h0, 32'hFFFF8899, 1'b0);
    txn("stb",    1'b1, 2'd0, 1'b0, 8'h13, 32'hFFFFFF5A, 32'h0, 1'b0);
    txn("stb chk",1'b0, 2'd2, 1'b1, 8'h10, 32'h0, 32'h5A99AABB, 1'b0);
    txn("sth",    1'b1, 2'd1, 1'b0, 8'h10, 32'hFFFF1234, 32'h0, 1'b0);
    txn("sth chk",1'b0, 2'd2, 1'b0, 8'h10, 32'h0, 32'h5A991234, 1'b0);

    // range and size errors
    txn("st top",  1'b1, 2'd2, 1'b0, 8'hFC, 32'hCAFEBABE, 32'h0, 1'b0);
    txn("ldh ovf", 1'b0, 2'd1, 1'b1, 8'hFF, 32'h0, 32'h0, 1'b1);
    txn("ldd big", 1'b0, 2'd3, 1'b0, 8'h00, 32'h0, 32'h0, 1'b1);
    txn("ld top",  1'b0, 2'd2, 1'b0, 8'hFC, 32'h0, 32'hCAFEBABE, 1'b0);
    txn("stb ovf", 1'b1, 2'd2, 1'b0, 8'hFE, 32'h01020304, 32'h0, 1'b1);
    txn("ld top2", 1'b0, 2'd2, 1'b0, 8'hFC, 32'h0, 32'hCAFEBABE, 1'b0);

    txn("st 0c", 1'b1, 2'd2, 1'b0, 8'h0C, 32'hA1B2C3D4, 32'h0, 1'b0);
    txn("st 10", 1'b1, 2'd2, 1'b0, 8'h10, 32'h55667788, 32'h0, 1'b0);

`ifdef RAM_MISALIGN_EN
    txn2("st x0e", 1'b1, 2'd2, 1'b0, 8'h0E, 32'h11223344, 32'h0);
    txn("ld 0c a", 1'b0, 2'd2, 1'b0, 8'h0C, 32'h0, 32'h3344C3D4, 1'b0);
    txn("ld 10 a", 1'b0, 2'd2, 1'b0, 8'h10, 32'h0, 32'h55661122, 1'b0);
    txn2("ld x0e", 1'b0, 2'd2, 1'b0, 8'h0E, 32'h0, 32'h11223344);
    txn2("ldh x0f", 1'b0, 2'd1, 1'b0, 8'h0F, 32'h0, 32'h00002233);
    txn("ldh 0d", 1'b0, 2'd1, 1'b0, 8'h0D, 32'h0, 32'h000044C3, 1'b0);

    // reset during the second beat of a crossing store
    @(negedge clk);
    drive(1'b1, 2'd2, 1'b0, 8'h0E, 32'hDEADBEEF);
    @(negedge clk);
    req_valid = 1'b0;
    check("abort busy", 32'(req_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    check("abort rdy", 32'(req_ready), 32'd1);
    check("abort vld0", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    check("abort vld1", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort vld2", 32'(rsp_valid), 32'd0);
    txn("abort 0c", 1'b0, 2'd2, 1'b0, 8'h0C, 32'h0, 32'hBEEFC3D4, 1'b0);
    txn("abort 10", 1'b0, 2'd2, 1'b0, 8'h10, 32'h0, 32'h55661122, 1'b0);
`else
    // misaligned accesses are rejected and leave memory alone
    txn("ldw mis",  1'b0, 2'd2, 1'b0, 8'h0E, 32'h0, 32'h0, 1'b1);
    txn("stw mis",  1'b1, 2'd2, 1'b0, 8'h0E, 32'hFFFFFFFF, 32'h0, 1'b1);
    txn("sth mis",  1'b1, 2'd1, 1'b0, 8'h0D, 32'hFFFFFFFF, 32'h0, 1'b1);
    check("mis rdy", 32'(req_ready), 32'd1);
    txn("ld 0c n",  1'b0, 2'd2, 1'b0, 8'h0C, 32'h0, 32'hA1B2C3D4, 1'b0);
    txn("ld 10 n",  1'b0, 2'd2, 1'b0, 8'h10, 32'h0, 32'h55667788, 1'b0);
`endif

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
